// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed 7-segment scan with a frame-synchronous double buffer; leading-zero blanking under SEG7_SCAN_LZB_EN
module seg7_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1000,
    parameter int GAP    = 16,
    parameter int CNT_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   iv_value,
    output logic                  o_ack,
    output logic [3:0]            ov_nibble,
    output logic [DIGITS-1:0]     ov_digit_en,
    output logic                  o_frame
);
    localparam int IW = $clog2(DIGITS);
    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] SHOW  = 1'b1;
    localparam logic [DIGITS-1:0] ONE = 1;

    logic [0:0]          state, n_state;
    logic [CNT_W-1:0]    cnt, n_cnt;
    logic [IW-1:0]       idx, n_idx;
    logic [4*DIGITS-1:0] active, n_active, pending, n_pending, src;
    logic                pending_valid, n_pv, gap_done, show_done, xfer, lit;

    // Slot sequencing, buffer transfer and the source of the upcoming nibble
    always_comb begin
        gap_done  = state == BLANK && cnt == CNT_W'(GAP - 1);
        show_done = state == SHOW && cnt == CNT_W'(DWELL - 1);
        xfer      = gap_done && idx == '0 && pending_valid;
        n_state   = gap_done ? SHOW : show_done ? BLANK : state;
        n_cnt     = (gap_done || show_done) ? '0 : cnt + 1'b1;
        n_idx     = show_done ? (idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1) : idx;
        n_active  = xfer ? pending : active;
        n_pending = i_load ? iv_value : pending;
        n_pv      = i_load | (pending_valid & ~xfer);
        src       = (n_state == BLANK && n_idx == '0 && n_pv) ? n_pending : n_active;
`ifdef SEG7_SCAN_LZB_EN
        lit       = n_idx == '0 || (n_active >> {n_idx, 2'b00}) != '0;
`else
        lit       = 1'b1;
`endif
    end

    // State registers plus outputs registered from next-state values so they align with the slot
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= BLANK;
            cnt           <= '0;
            idx           <= '0;
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            o_ack         <= 1'b0;
            ov_nibble     <= '0;
            ov_digit_en   <= '0;
            o_frame       <= 1'b0;
        end else begin
            state         <= n_state;
            cnt           <= n_cnt;
            idx           <= n_idx;
            active        <= n_active;
            pending       <= n_pending;
            pending_valid <= n_pv;
            o_ack         <= xfer;
            ov_nibble     <= src[{n_idx, 2'b00} +: 4];
            ov_digit_en   <= (n_state == SHOW && lit) ? ONE << n_idx : '0;
            o_frame       <= n_state == SHOW && n_cnt == CNT_W'(DWELL - 1) && n_idx == IW'(DIGITS - 1);
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: self-checking bench for seg7_scan_ctrl (DIGITS=4, DWELL=4, GAP=2)
module tb_seg7_scan_ctrl;
    localparam int FRAME = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld  = 1'b0;
    logic [15:0] val = '0;
    logic        ack, frame;
    logic [3:0]  nib, en;

    seg7_scan_ctrl #(.DIGITS(4), .DWELL(4), .GAP(2), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_load(ld), .iv_value(val),
        .o_ack(ack), .ov_nibble(nib), .ov_digit_en(en), .o_frame(frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] en;
        logic [3:0] nib;
        logic       fr;
        logic       ack;
    } vec_t;

    vec_t        tab[14];
    int          checks = 0;
    int          failures = 0;
    int          t = 0;
    bit          use_tab = 0;
    logic [15:0] m_act, m_pend;
    logic        m_pv;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    function automatic bit lit_of(input int s, input logic [15:0] a);
`ifdef SEG7_SCAN_LZB_EN
        return s == 0 || (a >> (4 * s)) != 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic step();
        logic        rst_s, ld_s, xfer;
        logic [15:0] val_s, e;
        int          p, s;
        bit          show;
        rst_s = rst; ld_s = ld; val_s = val;
        @(posedge clk);
        #1;
        ld = 1'b0;
        xfer = 1'b0;
        if (rst_s) begin
            t = 0; m_act = '0; m_pend = '0; m_pv = 1'b0;
        end else begin
            t++;
            xfer = (t % FRAME == 2) && m_pv;
            if (xfer) begin
                m_act = m_pend; m_pv = 1'b0; exp_q.push_back(m_pend);
            end
            if (ld_s) begin
                m_pend = val_s; m_pv = 1'b1;
            end
        end
        p = t % FRAME; s = p / 6; show = (p % 6) >= 2;
        chk("en", en, (show && lit_of(s, m_act)) ? 4'(1 << s) : 4'h0);
        chk("nibble", nib, (!show && s == 0 && m_pv) ? m_pend[3:0] : m_act[4*s +: 4]);
        chk("frame", frame, p == FRAME - 1);
        chk("ack", ack, xfer);
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) chk("ack_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("ack_value", nib, e[3:0]);
            end
        end
        if (use_tab)
            for (int k = 0; k < 14; k++)
                if (tab[k].cyc == t) begin
                    chk("tab_en", en, tab[k].en);
                    chk("tab_nib", nib, tab[k].nib);
                    chk("tab_fr", frame, tab[k].fr);
                    chk("tab_ack", ack, tab[k].ack);
                end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic run_to(input int c);
        while (t < c) step();
    endtask

    initial begin
        tab[0]  = '{0,  4'h0, 4'h0, 1'b0, 1'b0};
        tab[1]  = '{1,  4'h0, 4'h0, 1'b0, 1'b0};
        tab[2]  = '{2,  4'h1, 4'h0, 1'b0, 1'b0};
        tab[3]  = '{5,  4'h1, 4'h0, 1'b0, 1'b0};
        tab[4]  = '{6,  4'h0, 4'h0, 1'b0, 1'b0};
        tab[5]  = '{8,  4'h2, 4'h0, 1'b0, 1'b0};
        tab[6]  = '{23, 4'h8, 4'h0, 1'b1, 1'b0};
        tab[7]  = '{25, 4'h0, 4'h4, 1'b0, 1'b0};
        tab[8]  = '{26, 4'h1, 4'h4, 1'b0, 1'b1};
        tab[9]  = '{30, 4'h0, 4'h3, 1'b0, 1'b0};
        tab[10] = '{32, 4'h2, 4'h3, 1'b0, 1'b0};
        tab[11] = '{38, 4'h4, 4'h2, 1'b0, 1'b0};
        tab[12] = '{47, 4'h8, 4'h1, 1'b1, 1'b0};
        tab[13] = '{48, 4'h0, 4'h4, 1'b0, 1'b0};

        // idle frame then load 1234 at cycle 5, checked against the table
        use_tab = 1;
        do_reset();
        run_to(5);
        ld = 1'b1; val = 16'h1234;
        run_to(62);
        use_tab = 0;
        chk("pre_rst_en", en, 4'h4);
        chk("pre_rst_nib", nib, 4'h2);
        // reset mid-SHOW of digit 2, with a load in the reset cycle that must be dropped
        rst = 1'b1; ld = 1'b1; val = 16'hFFFF;
        step();
        rst = 1'b0;
        chk("rst_en", en, 4'h0);
        chk("rst_nib", nib, 4'h0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_frame", frame, 1'b0);
        run_to(50);
        chk("rst_q_empty", exp_q.size(), 0);

        // two loads in one frame: last wins, single ack
        do_reset();
        run_to(3);
        ld = 1'b1; val = 16'hAAAA;
        run_to(10);
        ld = 1'b1; val = 16'h5555;
        run_to(26);
        chk("last_wins_ack", ack, 1'b1);
        chk("last_wins_nib", nib, 4'h5);
        run_to(60);
        chk("last_wins_q", exp_q.size(), 0);

        // load landing on the transfer edge
        do_reset();
        run_to(3);
        ld = 1'b1; val = 16'h1111;
        run_to(25);
        ld = 1'b1; val = 16'h2222;
        run_to(26);
        chk("coinc_ack1", ack, 1'b1);
        chk("coinc_nib1", nib, 4'h1);
        run_to(50);
        chk("coinc_ack2", ack, 1'b1);
        chk("coinc_nib2", nib, 4'h2);
        run_to(60);
        chk("coinc_q", exp_q.size(), 0);

        // leading-zero blanking behaviour with 0050
        do_reset();
        ld = 1'b1; val = 16'h0050;
        run_to(32);
        chk("lzb_d1", en, 4'h2);
        run_to(38);
`ifdef SEG7_SCAN_LZB_EN
        chk("lzb_d2", en, 4'h0);
        run_to(44);
        chk("lzb_d3", en, 4'h0);
`else
        chk("lzb_d2", en, 4'h4);
        run_to(44);
        chk("lzb_d3", en, 4'h8);
`endif
        run_to(47);
        chk("lzb_frame", frame, 1'b1);
        run_to(50);
        chk("lzb_d0", en, 4'h1);
        chk("lzb_q", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
